// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared widths, scan state and hex-to-segment table for seg_scan_ctrl
package seg_pkg;

  localparam int SEG_W    = 7;
  localparam int NIBBLE_W = 4;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

  // Active-high patterns {a,b,c,d,e,f,g}, a = bit 6, indexed by nibble 0..F.
  localparam logic [SEG_W-1:0] SEG_TABLE [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

endpackage

// File: rtl/hex_seg_lut.sv
// rtl/hex_seg_lut.sv - combinational nibble to active-high 7-segment pattern
module hex_seg_lut
  import seg_pkg::*;
(
  input  logic [NIBBLE_W-1:0] nibble,
  output logic [SEG_W-1:0]    pattern
);

  assign pattern = SEG_TABLE[nibble];

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - multiplexed common-anode 7-segment scan controller
// Optional leading-zero suppression: SEG_LEADING_ZERO_BLANK_EN
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV   = 100000,
  parameter int BLANK_CYC  = 200
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           en_i,
  input  logic [NIBBLE_W*NUM_DIGITS-1:0] value_i,
  input  logic                           load_i,
  input  logic [NUM_DIGITS-1:0]          dp_i,
  output logic                           busy_o,
  output logic [NUM_DIGITS-1:0]          an_o,
  output logic [SEG_W-1:0]               seg_o,
  output logic                           dp_o
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);

  scan_state_t                    state;
  logic [CNT_W-1:0]               cnt;
  logic [IDX_W-1:0]               idx;
  logic [NIBBLE_W*NUM_DIGITS-1:0] disp;
  logic [NIBBLE_W*NUM_DIGITS-1:0] shadow;
  logic                           busy;
  logic                           en_q;

  scan_state_t         cur_state;
  logic [CNT_W-1:0]    cur_cnt;
  logic                restart;
  logic                slot_end;
  logic                blank_end;
  logic                wrap;
  logic [NIBBLE_W-1:0] nibble;
  logic                dp_sel;
  logic                show_sel;
  logic                show;
  logic [SEG_W-1:0]    pattern;

  // The first enabled cycle after a pause behaves as slot start, so registers can simply hold while disabled.
  assign restart   = en_i & ~en_q;
  assign cur_state = restart ? BLANK : state;
  assign cur_cnt   = restart ? '0 : cnt;
  assign slot_end  = (cur_cnt == LAST_CNT);
  assign blank_end = (BLANK_CYC == 0) || (cur_cnt == BLANK_END);
  assign wrap      = en_i && (cur_state == DRIVE) && slot_end && (idx == LAST_IDX);
  assign busy_o    = busy;

  always_comb begin
    logic zero_above;
    nibble     = '0;
    dp_sel     = 1'b0;
    show_sel   = 1'b1;
    zero_above = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above && (disp[i*NIBBLE_W +: NIBBLE_W] == '0);
      if (idx == IDX_W'(i)) begin
        nibble   = disp[i*NIBBLE_W +: NIBBLE_W];
        dp_sel   = dp_i[i];
        show_sel = (i == 0) || !zero_above || dp_i[i];
      end
    end
  end

`ifdef SEG_LEADING_ZERO_BLANK_EN
  assign show = show_sel;
`else
  assign show = 1'b1;
`endif

  hex_seg_lut u_lut (
    .nibble  (nibble),
    .pattern (pattern)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= BLANK;
      cnt    <= '0;
      idx    <= '0;
      disp   <= '0;
      shadow <= '0;
      busy   <= 1'b0;
      en_q   <= 1'b0;
      an_o   <= '1;
      seg_o  <= '1;
      dp_o   <= 1'b1;
    end else begin
      en_q <= en_i;
      if (load_i) begin
        shadow <= value_i;
        busy   <= 1'b1;
      end
      // Commit only at frame boundary; a coincident load stays pending for the next frame.
      if (wrap) begin
        disp <= shadow;
        if (!load_i) busy <= 1'b0;
      end
      if (en_i) begin
        cnt <= slot_end ? '0 : cur_cnt + CNT_W'(1);
        unique case (cur_state)
          BLANK: state <= blank_end ? DRIVE : BLANK;
          DRIVE: begin
            if (slot_end) begin
              idx   <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
              state <= (BLANK_CYC == 0) ? DRIVE : BLANK;
            end else begin
              state <= DRIVE;
            end
          end
        endcase
        if ((cur_state == DRIVE) && show) begin
          an_o  <= ~(NUM_DIGITS'(1) << idx);
          seg_o <= ~pattern;
          dp_o  <= ~dp_sel;
        end else begin
          an_o  <= '1;
          seg_o <= '1;
          dp_o  <= 1'b1;
        end
      end else begin
        an_o  <= '1;
        seg_o <= '1;
        dp_o  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - directed table-driven bench for seg_scan_ctrl
module tb_seg_scan_ctrl;

`ifdef SEG_LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  typedef struct {
    logic [15:0]     value;
    logic [3:0]      dp;
    logic [3:0]      lit;
    logic [3:0][6:0] seg;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [15:0] value;
  logic        load;
  logic [3:0]  dp;
  logic [3:0]  dp2;
  logic        busy, busy2;
  logic [3:0]  an, an2;
  logic [6:0]  seg, seg2;
  logic        dpo, dpo2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.NUM_DIGITS(4), .TICK_DIV(8), .BLANK_CYC(2)) dut (
    .clk(clk), .rst_n(rst_n), .en_i(en), .value_i(value), .load_i(load), .dp_i(dp),
    .busy_o(busy), .an_o(an), .seg_o(seg), .dp_o(dpo)
  );

  seg_scan_ctrl #(.NUM_DIGITS(4), .TICK_DIV(3), .BLANK_CYC(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .en_i(en), .value_i(value), .load_i(load), .dp_i(dp2),
    .busy_o(busy2), .an_o(an2), .seg_o(seg2), .dp_o(dpo2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered right after the wrap edge; checks the 32 output cycles of the following frame.
  task automatic check_frame(input vec_t v, input string tag);
    logic [11:0] exp;
    for (int k = 0; k < 4; k++) begin
      for (int j = 1; j <= 8; j++) begin
        step();
        if (j <= 2 || !v.lit[k]) exp = {4'hF, 7'h7F, 1'b1};
        else exp = {~(4'b0001 << k), v.seg[k], ~v.dp[k]};
        check($sformatf("%s d%0d c%0d", tag, k, j), {20'd0, an, seg, dpo}, {20'd0, exp});
      end
    end
  endtask

  task automatic wait_commit(input string tag);
    int n;
    n = 0;
    while (busy && n < 200) begin
      step();
      n++;
    end
    check({tag, " commit"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    value = v.value;
    dp    = v.dp;
    load  = 1'b1;
    step();
    load  = 1'b0;
    check({tag, " busy"}, {31'd0, busy}, 32'd1);
    wait_commit(tag);
    check_frame(v, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    vec_t vecs[6];
    vec_t zv, tv;
    int   id, n;
    logic bad;

    vecs[0] = '{16'h1234, 4'b0000, 4'b1111, {7'h4F, 7'h12, 7'h06, 7'h4C}};
    vecs[1] = '{16'h89AB, 4'b0101, 4'b1111, {7'h00, 7'h04, 7'h08, 7'h60}};
    vecs[2] = '{16'hCDEF, 4'b1000, 4'b1111, {7'h31, 7'h42, 7'h30, 7'h38}};
    vecs[3] = '{16'h5670, 4'b0000, 4'b1111, {7'h24, 7'h20, 7'h0F, 7'h01}};
    vecs[4] = '{16'h0070, 4'b0000, LZB ? 4'b0011 : 4'b1111, {7'h01, 7'h01, 7'h0F, 7'h01}};
    vecs[5] = '{16'h0070, 4'b1000, LZB ? 4'b1011 : 4'b1111, {7'h01, 7'h01, 7'h0F, 7'h01}};
    zv      = '{16'h0000, 4'b0000, LZB ? 4'b0001 : 4'b1111, {7'h01, 7'h01, 7'h01, 7'h01}};
    tv      = '{16'h0F0F, 4'b0000, LZB ? 4'b0111 : 4'b1111, {7'h01, 7'h38, 7'h01, 7'h38}};

    rst_n = 1'b0; en = 1'b1; load = 1'b0; value = '0; dp = '0; dp2 = 4'b1111;
    repeat (3) step();
    check("reset an", {28'd0, an}, 32'hF);
    check("reset seg", {25'd0, seg}, 32'h7F);
    check("reset dp", {31'd0, dpo}, 32'd1);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset an2", {28'd0, an2}, 32'hF);
    rst_n = 1'b1;

    // Zero-blank variant: after the short first slot, some anode is always on.
    for (int e = 1; e <= 28; e++) begin
      step();
      if (e == 1) begin
        check("nb first", {20'd0, an2, seg2, dpo2}, {20'd0, 4'hF, 7'h7F, 1'b1});
      end else begin
        id = (e <= 3) ? 0 : ((e - 4) / 3 + 1) % 4;
        check($sformatf("nb e%0d", e), {20'd0, an2, seg2, dpo2},
              {20'd0, ~(4'b0001 << id), 7'h01, 1'b0});
      end
    end

    for (int v = 0; v < 6; v++) run_vec(vecs[v], $sformatf("vec%0d", v));

    // Two loads mid-frame: only the last one may ever reach the display.
    dp = '0;
    repeat (10) step();
    value = 16'hABCD; load = 1'b1; step();
    load = 1'b0; step();
    value = 16'h0F0F; load = 1'b1; step();
    load = 1'b0;
    n = 0;
    while (busy && n < 200) begin
      bad = (an != 4'hF) && (seg == 7'h08 || seg == 7'h60 || seg == 7'h31 || seg == 7'h42);
      check("no tear", {31'd0, bad}, 32'd0);
      step();
      n++;
    end
    check("tear commit", {31'd0, busy}, 32'd0);
    check_frame(tv, "tear");

    // Pause scanning during digit 2's lit phase.
    repeat (20) step();
    check("pre-pause d2", {20'd0, an, seg, dpo}, {20'd0, 4'b1011, 7'h38, 1'b1});
    en = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step();
      check($sformatf("paused c%0d", c), {20'd0, an, seg, dpo}, {20'd0, 4'hF, 7'h7F, 1'b1});
    end
    en = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (c <= 2 || c >= 9)
        check($sformatf("resume c%0d", c), {20'd0, an, seg, dpo}, {20'd0, 4'hF, 7'h7F, 1'b1});
      else
        check($sformatf("resume c%0d", c), {20'd0, an, seg, dpo}, {20'd0, 4'b1011, 7'h38, 1'b1});
    end
    step();
    check("resume d3", {20'd0, an, seg, dpo},
          LZB ? {20'd0, 4'hF, 7'h7F, 1'b1} : {20'd0, 4'b0111, 7'h01, 1'b1});

    // Asynchronous reset while a digit is lit and a load is pending.
    value = 16'h1111; load = 1'b1; step();
    load = 1'b0;
    check("pre-reset busy", {31'd0, busy}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("async an", {28'd0, an}, 32'hF);
    check("async seg", {25'd0, seg}, 32'h7F);
    check("async dp", {31'd0, dpo}, 32'd1);
    check("async busy", {31'd0, busy}, 32'd0);
    #1;
    rst_n = 1'b1;
    check_frame(zv, "post-reset f0");
    check_frame(zv, "post-reset f1");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
